// File: rtl/referee_pkg.sv
// referee_pkg -- shared definitions for the round-robin referee.
//   ST_RESET/ST_INIT/ST_IDLE/ST_ACTIVE : one-hot system FSM state encodings
//   dest_of()                          : extracts the destination field of a word
package referee_pkg;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  // Words up to 64 bits wide; the field is [lsb +: $clog2(n_dst)], and
  // n_dst is a power of two, so masking with n_dst-1 yields the field.
  function automatic int unsigned dest_of(input logic [63:0] word,
                                          input int unsigned lsb,
                                          input int unsigned n_dst);
    int unsigned f;
    f = 32'(word >> lsb) & (n_dst - 1);
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index; the scan runs upward and wraps
//   gnt       : one-hot (or zero) grant
//   gnt_idx   : index of the granted requester
//   gnt_valid : a grant was issued
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  always_comb begin
    int unsigned j;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(j);
        gnt[j]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/referee_rr.sv
// referee_rr -- round-robin referee: moves at most one word per cycle from
// N_SRC FWFT source FIFOs to N_DST destination FIFOs chosen by a field in
// the word, honouring per-destination almost_full.
//   clk, reset  : clock, synchronous active-high reset
//   state       : one-hot system FSM state; only ST_ACTIVE moves data
//   empty_f     : per-source empty flags
//   data_in     : source head words, source i at [i*LINE_SIZE +: LINE_SIZE]
//   almost_full : per-destination back-pressure
//   pop         : combinational one-hot pop to the granted source
//   push        : registered one-hot push to a destination
//   data_out    : registered word accompanying push
//   grant_id    : registered index of the last granted source
//   idle        : no eligible source and no push in flight
//   push_count  : per-destination saturating 8-bit push counters, present
//                 only when REFEREE_COUNT_EN is defined
module referee_rr
  import referee_pkg::*;
#(
  parameter  int LINE_SIZE = 12,
  parameter  int N_SRC     = 4,
  parameter  int N_DST     = 4,
  parameter  int DEST_LSB  = 8,
  localparam int SW        = $clog2(N_SRC),
  localparam int DW        = $clog2(N_DST)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               state,
  input  logic [N_SRC-1:0]         empty_f,
  input  logic [N_SRC*LINE_SIZE-1:0] data_in,
  input  logic [N_DST-1:0]         almost_full,
  output logic [N_SRC-1:0]         pop,
  output logic [N_DST-1:0]         push,
  output logic [LINE_SIZE-1:0]     data_out,
  output logic [SW-1:0]            grant_id,
  output logic                     idle
`ifdef REFEREE_COUNT_EN
  ,
  output logic [N_DST*8-1:0]       push_count
`endif
);

  logic [SW-1:0]        ptr;
  logic [DW-1:0]        dest [N_SRC];
  logic [N_SRC-1:0]     req;
  logic [N_SRC-1:0]     gnt;
  logic [SW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic [LINE_SIZE-1:0] gnt_word;
  logic [DW-1:0]        gnt_dest;
  logic                 active;

  assign active = (state == ST_ACTIVE) && !reset;

  // The registered push vector doubles as the in-flight flag: a source
  // aiming at a destination being pushed this cycle waits, so at most one
  // unseen push per destination can land beyond almost_full.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      dest[i] = DW'(dest_of(64'(data_in[i*LINE_SIZE +: LINE_SIZE]), DEST_LSB, N_DST));
      req[i]  = active && !empty_f[i] && !almost_full[dest[i]] && !push[dest[i]];
    end
  end

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_word = '0;
    gnt_dest = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        gnt_word = data_in[i*LINE_SIZE +: LINE_SIZE];
        gnt_dest = dest[i];
      end
    end
  end

  assign pop  = gnt;
  assign idle = !(|req) && !(|push);

  always_ff @(posedge clk) begin
    if (reset) begin
      push     <= '0;
      data_out <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else if (gnt_valid) begin
      push     <= N_DST'(1) << gnt_dest;
      data_out <= gnt_word;
      grant_id <= gnt_idx;
      ptr      <= (gnt_idx == SW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      push <= '0;
    end
  end

`ifdef REFEREE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || state == ST_INIT) begin
      push_count <= '0;
    end else begin
      for (int unsigned d = 0; d < N_DST; d++) begin
        if (push[d] && push_count[d*8 +: 8] != 8'hFF)
          push_count[d*8 +: 8] <= push_count[d*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_referee_rr.sv
module tb_referee_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [3:0]  empty_f;
  logic [47:0] data_in;
  logic [3:0]  almost_full;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [11:0] data_out;
  logic [1:0]  grant_id;
  logic        idle;
`ifdef REFEREE_COUNT_EN
  logic [31:0] push_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  referee_rr #(.LINE_SIZE(12), .N_SRC(4), .N_DST(4), .DEST_LSB(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .empty_f     (empty_f),
    .data_in     (data_in),
    .almost_full (almost_full),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .idle        (idle)
`ifdef REFEREE_COUNT_EN
    ,
    .push_count  (push_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    state       = 4'b0001;
    empty_f     = 4'b0000;
    data_in     = {12'h04C, 12'h36E, 12'h26C, 12'h1E4};
    almost_full = 4'b0000;
    step(); step();
    chk("rst_pop",   32'(pop), 'h0);
    chk("rst_push",  32'(push), 'h0);
    chk("rst_data",  32'(data_out), 'h0);
    chk("rst_gid",   32'(grant_id), 'h0);
    chk("rst_idle",  32'(idle), 'h1);
    state = 4'b1000;
    settle();
    chk("rst_pop_active", 32'(pop), 'h0);
    chk("rst_idle_active", 32'(idle), 'h1);
    step();
    chk("rst_push_active", 32'(push), 'h0);

    // Four sources, four destinations, consecutive grants
    reset = 1'b0;
    settle();
    chk("seq_pop0", 32'(pop), 'h1);
    chk("seq_push_lat", 32'(push), 'h0);
    step();
    chk("seq_push0", 32'(push), 'h2);
    chk("seq_data0", 32'(data_out), 'h1E4);
    chk("seq_gid0",  32'(grant_id), 'h0);
    settle();
    chk("seq_pop1", 32'(pop), 'h2);
    step();
    chk("seq_push1", 32'(push), 'h4);
    chk("seq_data1", 32'(data_out), 'h26C);
    chk("seq_gid1",  32'(grant_id), 'h1);
    settle();
    chk("seq_pop2", 32'(pop), 'h4);
    step();
    chk("seq_push2", 32'(push), 'h8);
    chk("seq_data2", 32'(data_out), 'h36E);
    settle();
    chk("seq_pop3", 32'(pop), 'h8);
    step();
    chk("seq_push3", 32'(push), 'h1);
    chk("seq_data3", 32'(data_out), 'h04C);
    chk("seq_gid3",  32'(grant_id), 'h3);
    empty_f = 4'b1111;
    settle();
    chk("drain_pop",  32'(pop), 'h0);
    chk("drain_idle_busy", 32'(idle), 'h0);
    step();
    chk("drain_push", 32'(push), 'h0);
    chk("drain_idle", 32'(idle), 'h1);
    chk("drain_data_hold", 32'(data_out), 'h04C);

    // almost_full skip and wrap back to src0 (pointer is 0 here)
    almost_full = 4'b0010;
    empty_f     = 4'b1100;
    settle();
    chk("af_skip_pop", 32'(pop), 'h2);
    step();
    chk("af_push", 32'(push), 'h4);
    chk("af_gid",  32'(grant_id), 'h1);
    empty_f     = 4'b1110;
    almost_full = 4'b0000;
    settle();
    chk("af_wrap_pop", 32'(pop), 'h1);
    step();
    chk("af_wrap_push", 32'(push), 'h2);
    chk("af_wrap_data", 32'(data_out), 'h1E4);
    chk("af_wrap_gid",  32'(grant_id), 'h0);
    almost_full = 4'b0010;
    settle();
    chk("af_same_cycle_pop", 32'(pop), 'h0);
    step();
    chk("af_same_cycle_push", 32'(push), 'h0);
    chk("af_blocked_idle", 32'(idle), 'h1);

    // Two sources both aiming at dest1; pointer is 1 here
    almost_full = 4'b0000;
    data_in     = {12'h04C, 12'h36E, 12'h1E5, 12'h1E4};
    empty_f     = 4'b1100;
    settle();
    chk("d1_pop_a", 32'(pop), 'h2);
    step();
    chk("d1_push_a", 32'(push), 'h2);
    chk("d1_data_a", 32'(data_out), 'h1E5);
    settle();
    chk("d1_pop_block_a", 32'(pop), 'h0);
    step();
    chk("d1_push_gap_a", 32'(push), 'h0);
    settle();
    chk("d1_pop_b", 32'(pop), 'h1);
    step();
    chk("d1_push_b", 32'(push), 'h2);
    chk("d1_data_b", 32'(data_out), 'h1E4);
    settle();
    chk("d1_pop_block_b", 32'(pop), 'h0);
    step();
    chk("d1_push_gap_b", 32'(push), 'h0);
    settle();
    chk("d1_pop_c", 32'(pop), 'h2);
    step();
    chk("d1_push_c", 32'(push), 'h2);

    // ACTIVE -> IDLE mid-stream; pointer is 2 here
    data_in = {12'h04C, 12'h36E, 12'h26C, 12'h1E4};
    empty_f = 4'b0000;
    settle();
    chk("st_pop_active", 32'(pop), 'h4);
    state = 4'b0100;
    settle();
    chk("st_pop_idle", 32'(pop), 'h0);
    step();
    chk("st_push_idle", 32'(push), 'h0);
    chk("st_data_hold", 32'(data_out), 'h1E5);
    step();
    chk("st_idle_flag", 32'(idle), 'h1);
    state = 4'b1000;
    settle();
    chk("st_resume_pop", 32'(pop), 'h4);
    step();
    chk("st_resume_push", 32'(push), 'h8);
    chk("st_resume_data", 32'(data_out), 'h36E);
    chk("st_resume_gid",  32'(grant_id), 'h2);

    // Reset mid-operation drops the pending push
    reset = 1'b1;
    settle();
    chk("mid_rst_pop", 32'(pop), 'h0);
    step();
    chk("mid_rst_push", 32'(push), 'h0);
    chk("mid_rst_data", 32'(data_out), 'h0);
    chk("mid_rst_gid",  32'(grant_id), 'h0);

`ifdef REFEREE_COUNT_EN
    state = 4'b0010;
    reset = 1'b0;
    step();
    chk("cnt_init", push_count, 'h0);
    empty_f = 4'b0111;
    state   = 4'b1000;
    for (int i = 0; i < 600; i++) step();
    chk("cnt_sat", 32'(push_count[7:0]), 'hFF);
    chk("cnt_other", 32'(push_count[31:8]), 'h0);
    reset = 1'b1;
    step();
    chk("cnt_rst", push_count, 'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
